// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream in and IF memory write port out of the instruction loader
interface instr_mem_loader_if #(
   parameter int PC_SIZE = 10
);
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic [PC_SIZE-1:0] PC_write;
   logic [31:0]        instruction_in;
   logic               reset_IF_memory;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output PC_write,
      output instruction_in,
      output reset_IF_memory
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  PC_write,
      input  instruction_in,
      input  reset_IF_memory
   );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a length-prefixed instruction stream into IF memory; LOADER_CHECKSUM_EN adds a trailing XOR check byte
module instr_mem_loader #(
   parameter int PC_SIZE = 10,
   parameter int PC_STEP = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_start,
   instr_mem_loader_if.master bus,
   output logic               core_reset,
   output logic               busy,
   output logic               done,
   output logic               error
);
   localparam int unsigned MAX_WORDS = (32'd1 << PC_SIZE) / PC_STEP;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_COLLECT,
      S_WRITE,
      S_DONE,
      S_ERROR
`ifdef LOADER_CHECKSUM_EN
      , S_CHECK
`endif
   } state_t;

   state_t state_q, state_d;

   logic rx_ready_q, rx_ready_d;
   logic wr_q, wr_d;
   logic core_reset_q, core_reset_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic error_q, error_d;

   logic [PC_SIZE-1:0] pc_q;
   logic [31:0]        instr_q;
   logic [15:0]        len_q;
   logic [15:0]        count_q;
   logic [1:0]         byte_idx_q;
   logic [23:0]        shift_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]         csum_q;
`endif

   logic        accept;
   logic        start_ok;
   logic [15:0] hdr_len;
   logic        len_bad;
   logic        last_word;

   // a byte moves only when the loader advertised ready and the source has data
   assign accept    = bus.rx_valid && rx_ready_q;
   assign start_ok  = load_start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
   assign hdr_len   = {bus.rx_data, len_q[7:0]};
   assign len_bad   = (hdr_len == 16'd0) || (32'(hdr_len) > MAX_WORDS);
   assign last_word = (count_q + 16'd1) == len_q;

   // state register plus registered control outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rx_ready_q   <= 1'b0;
         wr_q         <= 1'b0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_d;
         wr_q         <= wr_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   // next state, and control outputs decoded from the state being entered
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (load_start) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) state_d = len_bad ? S_ERROR : S_COLLECT;
         end
         S_COLLECT: begin
            if (accept && (byte_idx_q == 2'd3)) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_COLLECT;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      rx_ready_d   = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_COLLECT);
`ifdef LOADER_CHECKSUM_EN
      if (state_d == S_CHECK) rx_ready_d = 1'b1;
`endif
      wr_d         = (state_d == S_WRITE);
      core_reset_d = (state_d != S_DONE);
      busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
      done_d       = (state_d == S_DONE);
      error_d      = (state_d == S_ERROR);
   end

   // header capture, little-endian word assembly, write address and word count
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= '0;
         instr_q    <= '0;
         len_q      <= '0;
         count_q    <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         if (start_ok) begin
            pc_q       <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
         end
         if (accept) begin
            case (state_q)
               S_LEN_LO: len_q[7:0]  <= bus.rx_data;
               S_LEN_HI: len_q[15:8] <= bus.rx_data;
               S_COLLECT: begin
                  // earlier bytes sink toward bit 0 so the first byte ends up least significant
                  shift_q    <= {bus.rx_data, shift_q[23:8]};
                  byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum_q     <= csum_q ^ bus.rx_data;
`endif
                  if (byte_idx_q == 2'd3) instr_q <= {bus.rx_data, shift_q};
               end
               default: ;
            endcase
         end
         if (state_q == S_WRITE) begin
            pc_q    <= pc_q + PC_SIZE'(PC_STEP);
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign bus.rx_ready        = rx_ready_q;
   assign bus.PC_write        = pc_q;
   assign bus.instruction_in  = instr_q;
   assign bus.reset_IF_memory = wr_q;
   assign core_reset          = core_reset_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign error               = error_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
   localparam int PC_SIZE   = 10;
   localparam int PC_STEP   = 4;
   localparam int MAX_WORDS = (1 << PC_SIZE) / PC_STEP;
`ifdef LOADER_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clock      = 1'b0;
   logic reset      = 1'b1;
   logic load_start = 1'b0;
   logic core_reset, busy, done, error;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   bit aborted = 1'b0;
`ifdef LOADER_CHECKSUM_EN
   bit csum_bad = 1'b0;
`endif

   logic [31:0]        words[$];
   logic [PC_SIZE-1:0] wr_pc[$];
   logic [31:0]        wr_data[$];

   instr_mem_loader_if #(.PC_SIZE(PC_SIZE)) bus ();

   instr_mem_loader #(.PC_SIZE(PC_SIZE), .PC_STEP(PC_STEP)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_start (load_start),
      .bus        (bus),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // record every memory write; a strobe must only appear mid-load with the stream paused
   always @(negedge clock) begin
      if (bus.reset_IF_memory === 1'b1) begin
         wr_pc.push_back(bus.PC_write);
         wr_data.push_back(bus.instruction_in);
         checks++;
         if (bus.rx_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL strobe_context rx_ready=%b busy=%b want rx_ready=0 busy=1", bus.rx_ready, busy);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      if (aborted) return;
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      t = 0;
      while (bus.rx_ready !== 1'b1 && t < 64) begin
         @(negedge clock);
         t++;
      end
      if (t >= 64) begin
         checks++;
         errors++;
         aborted = 1'b1;
         bus.rx_valid = 1'b0;
         $display("FAIL rx_handshake byte %h not accepted within 64 cycles", b);
         return;
      end
      @(negedge clock);
      bus.rx_valid = 1'b0;
   endtask

   // builds the byte stream for words[] behind header n and drives a complete load
   task automatic run_load(input logic [15:0] n, input int max_gap, input int stall_at,
                           input int glitch_at, output int cycles);
      logic [7:0] stream[$];
      int c0;
      int t;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] csum;
      csum = 8'h00;
`endif
      stream.push_back(n[7:0]);
      stream.push_back(n[15:8]);
      if (n != 16'd0 && int'(n) <= MAX_WORDS) begin
         foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
               stream.push_back(words[i][8*k +: 8]);
`ifdef LOADER_CHECKSUM_EN
               csum = csum ^ words[i][8*k +: 8];
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         stream.push_back(csum_bad ? (csum ^ 8'h12) : csum);
`endif
      end
      aborted = 1'b0;
      wr_pc.delete();
      wr_data.delete();
      c0 = cyc;
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      foreach (stream[j]) begin
         if (j == glitch_at) begin
            load_start = 1'b1;
            @(negedge clock);
            load_start = 1'b0;
         end
         send_byte(stream[j], (j == stall_at) ? 5 : $urandom_range(0, max_gap));
      end
      t = 0;
      while (busy === 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (t >= 100) begin
         checks++;
         errors++;
         $display("FAIL load_finish busy still %b after stream", busy);
      end
      cycles = cyc - c0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clock);
      checks++;
      if ({core_reset, bus.rx_ready, bus.reset_IF_memory, busy, done, error} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 100000",
                  {core_reset, bus.rx_ready, bus.reset_IF_memory, busy, done, error});
      end
      checks++;
      if (bus.PC_write !== '0) begin
         errors++;
         $display("FAIL reset_pc got %h want 0", bus.PC_write);
      end
      checks++;
      if (bus.instruction_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_instr got %h want 0", bus.instruction_in);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_single_word();
      int cycles;
      words = {32'h00A00513};
      run_load(16'd1, 0, -1, -1, cycles);
      checks++;
      if (wr_pc.size() != 1 || wr_pc[0] !== '0 || wr_data[0] !== 32'h00A00513) begin
         errors++;
         $display("FAIL single_write count=%0d pc=%h data=%h want 1 000 00a00513",
                  wr_pc.size(), wr_pc[0], wr_data[0]);
      end
      checks++;
      if ({done, error, busy, core_reset} !== 4'b1000) begin
         errors++;
         $display("FAIL single_status got %b want 1000", {done, error, busy, core_reset});
      end
      checks++;
      if (cycles != 3 + 5 + EXTRA) begin
         errors++;
         $display("FAIL single_latency got %0d want %0d", cycles, 3 + 5 + EXTRA);
      end
   endtask

   task automatic test_stall();
      int cycles;
      logic [PC_SIZE-1:0] exp_pc;
      words = {$urandom, $urandom, $urandom};
      run_load(16'd3, 0, 2 + 4 + 2, -1, cycles);
      checks++;
      if (wr_pc.size() != 3) begin
         errors++;
         $display("FAIL stall_strobes got %0d want 3", wr_pc.size());
      end
      foreach (words[i]) begin
         exp_pc = PC_SIZE'((i * PC_STEP) % (1 << PC_SIZE));
         checks++;
         if (i >= wr_pc.size() || wr_pc[i] !== exp_pc || wr_data[i] !== words[i]) begin
            errors++;
            $display("FAIL stall_word%0d pc=%h data=%h want %h %h", i, wr_pc[i], wr_data[i], exp_pc, words[i]);
         end
      end
      checks++;
      if ({done, error, core_reset} !== 3'b100) begin
         errors++;
         $display("FAIL stall_status got %b want 100", {done, error, core_reset});
      end
   endtask

   task automatic test_random_loads();
      int cycles;
      int n;
      logic [PC_SIZE-1:0] exp_pc;
      for (int r = 0; r < 7; r++) begin
         n = (r == 6) ? MAX_WORDS : $urandom_range(1, 8);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         run_load(16'(n), (r == 6) ? 0 : 3, -1, -1, cycles);
         checks++;
         if (wr_pc.size() != n) begin
            errors++;
            $display("FAIL rand%0d_count got %0d want %0d", r, wr_pc.size(), n);
         end
         foreach (words[i]) begin
            exp_pc = PC_SIZE'((i * PC_STEP) % (1 << PC_SIZE));
            checks++;
            if (i >= wr_pc.size() || wr_pc[i] !== exp_pc || wr_data[i] !== words[i]) begin
               errors++;
               $display("FAIL rand%0d_word%0d pc=%h data=%h want %h %h", r, i, wr_pc[i], wr_data[i], exp_pc, words[i]);
            end
         end
         checks++;
         if ({done, error, busy, core_reset} !== 4'b1000) begin
            errors++;
            $display("FAIL rand%0d_status got %b want 1000", r, {done, error, busy, core_reset});
         end
         if (r == 6) begin
            checks++;
            if (cycles != 3 + 5 * MAX_WORDS + EXTRA) begin
               errors++;
               $display("FAIL full_latency got %0d want %0d", cycles, 3 + 5 * MAX_WORDS + EXTRA);
            end
         end
      end
   endtask

   task automatic test_bad_length();
      int cycles;
      logic [15:0] lens[2];
      lens[0] = 16'd0;
      lens[1] = 16'(MAX_WORDS + 1);
      foreach (lens[i]) begin
         words.delete();
         run_load(lens[i], 2, -1, -1, cycles);
         checks++;
         if (wr_pc.size() != 0) begin
            errors++;
            $display("FAIL badlen%0d_strobes got %0d want 0", lens[i], wr_pc.size());
         end
         checks++;
         if ({error, core_reset, done, busy, bus.rx_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL badlen%0d_status got %b want 11000", lens[i],
                     {error, core_reset, done, busy, bus.rx_ready});
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int cycles;
      logic [31:0] w0, w1;
      w0 = $urandom;
      w1 = $urandom;
      aborted = 1'b0;
      wr_pc.delete();
      wr_data.delete();
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
      send_byte(w1[7:0], 0);
      send_byte(w1[15:8], 0);
      checks++;
      if (wr_pc.size() != 1 || bus.PC_write !== PC_SIZE'(PC_STEP)) begin
         errors++;
         $display("FAIL midreset_pre writes=%0d pc=%h want 1 %h", wr_pc.size(), bus.PC_write, PC_SIZE'(PC_STEP));
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if ({core_reset, bus.rx_ready, busy, done, error} !== 5'b10000 || bus.PC_write !== '0) begin
         errors++;
         $display("FAIL midreset_state ctrl=%b pc=%h want 10000 000",
                  {core_reset, bus.rx_ready, busy, done, error}, bus.PC_write);
      end
      words = {$urandom, $urandom};
      run_load(16'd2, 1, -1, -1, cycles);
      checks++;
      if (wr_pc.size() != 2 || wr_data[0] !== words[0] || wr_data[1] !== words[1] ||
          wr_pc[1] !== PC_SIZE'(PC_STEP) || done !== 1'b1) begin
         errors++;
         $display("FAIL midreset_reload count=%0d d0=%h d1=%h done=%b want 2 %h %h 1",
                  wr_pc.size(), wr_data[0], wr_data[1], done, words[0], words[1]);
      end
   endtask

   task automatic test_start_ignored();
      int cycles;
      words = {$urandom, $urandom, $urandom};
      run_load(16'd3, 1, -1, 2 + 4 + 2, cycles);
      checks++;
      if (wr_pc.size() != 3 || wr_data[0] !== words[0] || wr_data[1] !== words[1] ||
          wr_data[2] !== words[2] || wr_pc[2] !== PC_SIZE'(2 * PC_STEP)) begin
         errors++;
         $display("FAIL ignore_start count=%0d d=%h %h %h want 3 %h %h %h", wr_pc.size(),
                  wr_data[0], wr_data[1], wr_data[2], words[0], words[1], words[2]);
      end
      checks++;
      if ({done, error, core_reset} !== 3'b100) begin
         errors++;
         $display("FAIL ignore_status got %b want 100", {done, error, core_reset});
      end
   endtask

   task automatic test_restart_from_done();
      int cycles;
      checks++;
      if (done !== 1'b1 || core_reset !== 1'b0) begin
         errors++;
         $display("FAIL restart_pre done=%b core_reset=%b want 1 0", done, core_reset);
      end
      words = {$urandom, $urandom};
      fork
         run_load(16'd2, 2, -1, -1, cycles);
         begin
            @(negedge clock);
            checks++;
            if ({core_reset, busy, done, bus.rx_ready} !== 4'b1101) begin
               errors++;
               $display("FAIL restart_entry got %b want 1101", {core_reset, busy, done, bus.rx_ready});
            end
         end
      join
      checks++;
      if (wr_pc.size() != 2 || wr_pc[0] !== '0 || wr_data[0] !== words[0] || wr_data[1] !== words[1]) begin
         errors++;
         $display("FAIL restart_load count=%0d pc0=%h d0=%h d1=%h want 2 000 %h %h",
                  wr_pc.size(), wr_pc[0], wr_data[0], wr_data[1], words[0], words[1]);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int cycles;
      words = {32'h00A00513, 32'h00000013};
      csum_bad = 1'b0;
      run_load(16'd2, 1, -1, -1, cycles);
      checks++;
      if ({done, error, core_reset} !== 3'b100 || wr_pc.size() != 2) begin
         errors++;
         $display("FAIL csum_good status=%b writes=%0d want 100 2", {done, error, core_reset}, wr_pc.size());
      end
      csum_bad = 1'b1;
      run_load(16'd2, 1, -1, -1, cycles);
      csum_bad = 1'b0;
      checks++;
      if ({done, error, core_reset} !== 3'b011 || wr_pc.size() != 2) begin
         errors++;
         $display("FAIL csum_bad status=%b writes=%0d want 011 2", {done, error, core_reset}, wr_pc.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_stall();
      test_random_loads();
      test_bad_length();
      test_reset_mid_load();
      test_start_ignored();
      test_restart_from_done();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
